vram_write_bridge: RTL
======================

// Module: vram_write_bridge
// PURPOSE
//  Upstream feed of the GPU video memories: accepts CPU bus writes (asynchronous cpu_clk domain),
//  brings them into the CLK100MHz domain and turns them into single-cycle write strobes for
//  tile (2K), attribute (4K) and color (16) memories. Holds an auto-incrementing 16-bit VRAM
//  pointer so the CPU streams bytes through one data register. Write-only; reads ignored.
// PARAMETERS
//  SYNC_STAGES   2   flops in cpu_clk synchroniser (>=2); bus inputs delayed to match
//  INCR_RESET    1   reset value of the pointer increment register
// PORTS
//  CLK100MHz                       in   1   system clock, all logic rising-edge
//  rst                             in   1   asynchronous reset, active-low
//  data                            in   8   CPU data bus
//  addr                            in   3   CPU register select
//  rw                              in   1   1 = read (ignored), 0 = write
//  cs                              in   1   chip select, active-low
//  cpu_clk                         in   1   CPU phi2, asynchronous to CLK100MHz
//  tile_memory_write_enable        out  1   one-CLK write strobe
//  tile_memory_write_addr          out  11  tile address (ptr[10:0])
//  tile_memory_write_data          out  8   write data
//  attribute_memory_write_enable   out  1   one-CLK write strobe
//  attribute_memory_write_addr     out  12  attribute address (ptr[11:0])
//  attribute_memory_write_data     out  8   write data
//  color_memory_write_enable       out  1   one-CLK write strobe
//  color_memory_write_addr         out  4   color address (ptr[3:0])
//  color_memory_write_data         out  8   write data
//  write_dropped                   out  1   one-CLK pulse: data write to unmapped ptr
// BEHAVIOUR
//  Reset (rst=0, async): all strobes/addr/data outputs 0, write_dropped 0, ptr=0x0000,
//   incr=INCR_RESET, synchroniser and bus delay line cleared to "cpu_clk low, cs high".
//  Capture: cpu_clk through SYNC_STAGES flops; {data,addr,rw,cs} sampled every CLK through an
//   equal-length delay line plus one stage, aligned with synced-prev. Bus access = synced
//   falling edge (prev=1,now=0); captured values are those aligned with prev (last high).
//   Access valid only if captured cs=0 and rw=0; otherwise no action.
//  Latency: edge k = first CLK edge sampling cpu_clk low; strobe/pointer update visible after
//   edge k+SYNC_STAGES, exactly one CLK wide. One access per cpu_clk period max.
//  Register map (addr):
//   0 PTR_LO   ptr[7:0]  <= data
//   1 PTR_HI   ptr[15:8] <= data
//   2 DATA     commit write at ptr, then ptr <= ptr + incr (16-bit, wraps 0xFFFF->0x0000)
//   3 INCR     incr <= data (0 legal: pointer holds)
//   4 DATA_NI  commit write at ptr, pointer unchanged
//   5-7        reserved, ignored
//  Commit decode on ptr (value before increment):
//   0x0000-0x07FF tile; 0x1000-0x1FFF attribute; 0x2000-0x200F color;
//   anything else: no strobe, write_dropped pulses, pointer still increments (addr 2).
//  Selected memory's addr/data outputs update with the strobe and hold until its next commit;
//   other memories' outputs unchanged. At most one strobe high per CLK.
//  FSM: IDLE -> (falling edge & valid) COMMIT (1 CLK, strobe high) -> IDLE. Pointer/INCR
//   writes complete in same edge without strobe.
//  cpu_clk high and low phases must each be >= SYNC_STAGES+2 CLK; shorter phases undefined.
//  Reset mid-access: pending commit discarded, strobe drops immediately; no partial pointer.
// TESTING
//  1 reset, PTR_LO=0x10, PTR_HI=0x00, DATA=0xAB -> tile we 1 CLK, addr 0x010, data 0xAB; ptr=0x0011
//  2 ptr=0x1FFF, INCR=2, DATA 0x55 x2 -> attr write @0xFFF, then write_dropped @0x2001? no: color @0x2001
//  3 ptr=0x0800, DATA=0x01 -> no strobe, write_dropped 1 CLK, ptr=0x0801
//  4 ptr=0xFFFF, DATA -> write_dropped, ptr wraps 0x0000; DATA_NI at 0x0000 x3 -> 3 tile writes @0x000
//  5 rw=1 or cs=1 across 10 cpu_clk periods -> no strobe, ptr/incr unchanged
//  6 rst low during COMMIT cycle -> strobe 0 same instant, ptr=0, incr=1 after release

Source files
------------

// File: rtl/vram_write_bridge_if.sv
// vram_write_bridge_if: CPU bus inputs and video-memory write ports of the VRAM write bridge.
interface vram_write_bridge_if;
    logic [7:0]  data;
    logic [2:0]  addr;
    logic        rw;
    logic        cs;
    logic        cpu_clk;
    logic        tile_memory_write_enable;
    logic [10:0] tile_memory_write_addr;
    logic [7:0]  tile_memory_write_data;
    logic        attribute_memory_write_enable;
    logic [11:0] attribute_memory_write_addr;
    logic [7:0]  attribute_memory_write_data;
    logic        color_memory_write_enable;
    logic [3:0]  color_memory_write_addr;
    logic [7:0]  color_memory_write_data;
    logic        write_dropped;
    modport master (
        output data, addr, rw, cs, cpu_clk,
        input  tile_memory_write_enable, tile_memory_write_addr, tile_memory_write_data,
        input  attribute_memory_write_enable, attribute_memory_write_addr, attribute_memory_write_data,
        input  color_memory_write_enable, color_memory_write_addr, color_memory_write_data,
        input  write_dropped
    );
    modport slave (
        input  data, addr, rw, cs, cpu_clk,
        output tile_memory_write_enable, tile_memory_write_addr, tile_memory_write_data,
        output attribute_memory_write_enable, attribute_memory_write_addr, attribute_memory_write_data,
        output color_memory_write_enable, color_memory_write_addr, color_memory_write_data,
        output write_dropped
    );
endinterface

// File: rtl/vram_write_bridge.sv
// vram_write_bridge: CPU-bus writes synchronised into CLK100MHz and turned into one-cycle
// tile/attribute/color memory strobes through an auto-incrementing VRAM pointer.
module vram_write_bridge #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  INCR_RESET  = 8'd1
) (
    input logic              CLK100MHz,
    input logic              rst,
    vram_write_bridge_if.slave bus
);
    typedef enum logic {IDLE, COMMIT} state_t;
    localparam logic [12:0] BUS_IDLE = 13'h0001;
    state_t                       r_state;
    logic [SYNC_STAGES-1:0]       r_sync;
    logic                         r_prev;
    logic [SYNC_STAGES:0][12:0]   r_bus;
    logic [15:0]                  r_ptr;
    logic [7:0]                   r_incr;
    logic [12:0] w_cap;
    logic [2:0]  w_addr;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_tile;
    logic        w_attr;
    logic        w_color;
    // The delay line is one stage longer than the synchroniser so the captured bus is the
    // sample taken on the last CLK edge that still saw cpu_clk high.
    assign w_cap   = r_bus[SYNC_STAGES];
    assign w_addr  = w_cap[4:2];
    assign w_data  = w_cap[12:5];
    assign w_valid = r_prev & ~r_sync[SYNC_STAGES-1] & ~w_cap[0] & ~w_cap[1];
    assign w_tile  = r_ptr[15:11] == 5'h00;
    assign w_attr  = r_ptr[15:12] == 4'h1;
    assign w_color = r_ptr[15:4] == 12'h200;
    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            r_state                           <= IDLE;
            r_sync                            <= '0;
            r_prev                            <= 1'b0;
            r_bus                             <= {(SYNC_STAGES+1){BUS_IDLE}};
            r_ptr                             <= 16'h0000;
            r_incr                            <= INCR_RESET;
            bus.tile_memory_write_enable      <= 1'b0;
            bus.tile_memory_write_addr        <= '0;
            bus.tile_memory_write_data        <= '0;
            bus.attribute_memory_write_enable <= 1'b0;
            bus.attribute_memory_write_addr   <= '0;
            bus.attribute_memory_write_data   <= '0;
            bus.color_memory_write_enable     <= 1'b0;
            bus.color_memory_write_addr       <= '0;
            bus.color_memory_write_data       <= '0;
            bus.write_dropped                 <= 1'b0;
        end else begin
            r_sync                            <= {r_sync[SYNC_STAGES-2:0], bus.cpu_clk};
            r_prev                            <= r_sync[SYNC_STAGES-1];
            r_bus                             <= {r_bus[SYNC_STAGES-1:0], {bus.data, bus.addr, bus.rw, bus.cs}};
            bus.tile_memory_write_enable      <= 1'b0;
            bus.attribute_memory_write_enable <= 1'b0;
            bus.color_memory_write_enable     <= 1'b0;
            bus.write_dropped                 <= 1'b0;
            case (r_state)
                IDLE: if (w_valid) begin
                    case (w_addr)
                        3'd0: r_ptr[7:0]  <= w_data;
                        3'd1: r_ptr[15:8] <= w_data;
                        3'd3: r_incr      <= w_data;
                        3'd2, 3'd4: begin
                            r_state <= COMMIT;
                            if (w_tile) begin
                                bus.tile_memory_write_enable <= 1'b1;
                                bus.tile_memory_write_addr   <= r_ptr[10:0];
                                bus.tile_memory_write_data   <= w_data;
                            end else if (w_attr) begin
                                bus.attribute_memory_write_enable <= 1'b1;
                                bus.attribute_memory_write_addr   <= r_ptr[11:0];
                                bus.attribute_memory_write_data   <= w_data;
                            end else if (w_color) begin
                                bus.color_memory_write_enable <= 1'b1;
                                bus.color_memory_write_addr   <= r_ptr[3:0];
                                bus.color_memory_write_data   <= w_data;
                            end else begin
                                bus.write_dropped <= 1'b1;
                            end
                            if (w_addr == 3'd2) r_ptr <= r_ptr + {8'h00, r_incr};
                        end
                        default: ;
                    endcase
                end
                COMMIT: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
